// File: rtl/i2c_slave_frontend.sv
// I2C slave bit/byte engine: synchronises SCL/SDA, tracks START/STOP, matches the device address,
// captures an 11-bit register pointer and write bytes, and shifts read bytes out.
module i2c_slave_frontend #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         SYNC     = 2
) (
  input  logic        Clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [7:0]  rd_data,
  output logic        i2c_RW,
  output logic [10:0] i2c_addr,
  output logic [7:0]  i2c_data,
  output logic        i2c_addr_ack,
  output logic        i2c_data_ack,
  output logic        stop
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG_HI, HI_ACK, REG_LO, LO_ACK, WR, WR_ACK, RD, RD_MACK, IGNORE
  } state_t;

  logic [SYNC-1:0] scl_sync, sda_sync;
  logic            scl_d, sda_d;
  logic            scl, sda;
  logic            scl_rise, scl_fall, start_det, stop_det;

  // Synchronisers reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge Clock) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC-2:0], sda_in};
      scl_d    <= scl_sync[SYNC-1];
      sda_d    <= sda_sync[SYNC-1];
    end
  end

  assign scl       = scl_sync[SYNC-1];
  assign sda       = sda_sync[SYNC-1];
  assign scl_rise  = scl & ~scl_d;
  assign scl_fall  = ~scl & scl_d;
  assign start_det = scl & scl_d & sda_d & ~sda;
  assign stop_det  = scl & scl_d & ~sda_d & sda;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  sh, sh_nxt;
  logic [6:0]  tx, tx_nxt;
  logic [2:0]  hi, hi_nxt;
  logic        oe_nxt, rw_nxt, aack_nxt, dack_nxt, stop_nxt;
  logic [10:0] addr_nxt;
  logic [7:0]  data_nxt;
  logic        bit_in, byte_done;

  assign bit_in    = scl_rise & ~cnt[3];
  assign byte_done = scl_fall & cnt[3];

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sh           <= '0;
      tx           <= '0;
      hi           <= '0;
      sda_oe       <= 1'b0;
      i2c_RW       <= 1'b0;
      i2c_addr     <= '0;
      i2c_data     <= '0;
      i2c_addr_ack <= 1'b0;
      i2c_data_ack <= 1'b0;
      stop         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      sh           <= sh_nxt;
      tx           <= tx_nxt;
      hi           <= hi_nxt;
      sda_oe       <= oe_nxt;
      i2c_RW       <= rw_nxt;
      i2c_addr     <= addr_nxt;
      i2c_data     <= data_nxt;
      i2c_addr_ack <= aack_nxt;
      i2c_data_ack <= dack_nxt;
      stop         <= stop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    tx_nxt    = tx;
    hi_nxt    = hi;
    oe_nxt    = sda_oe;
    rw_nxt    = i2c_RW;
    addr_nxt  = i2c_addr;
    data_nxt  = i2c_data;
    aack_nxt  = i2c_addr_ack;
    dack_nxt  = i2c_data_ack;
    stop_nxt  = 1'b0;

    if (start_det) begin
      state_nxt = DEV;
      cnt_nxt   = '0;
      oe_nxt    = 1'b0;
      aack_nxt  = 1'b0;
      dack_nxt  = 1'b0;
    end else if (stop_det) begin
      state_nxt = IDLE;
      stop_nxt  = 1'b1;
      oe_nxt    = 1'b0;
      aack_nxt  = 1'b0;
      dack_nxt  = 1'b0;
    end else begin
      if ((state inside {DEV, REG_HI, REG_LO, WR}) && bit_in) begin
        sh_nxt  = {sh[6:0], sda};
        cnt_nxt = cnt + 4'd1;
      end
      case (state)
        DEV: if (byte_done) begin
          cnt_nxt = '0;
          if (sh[7:1] == DEV_ADDR) begin
            oe_nxt    = 1'b1;
            rw_nxt    = ~sh[0];
            aack_nxt  = sh[0];
            state_nxt = DEV_ACK;
          end else begin
            state_nxt = IGNORE;
          end
        end
        DEV_ACK: if (scl_fall) begin
          aack_nxt = 1'b0;
          if (i2c_RW) begin
            oe_nxt    = 1'b0;
            state_nxt = REG_HI;
          end else begin
            tx_nxt    = rd_data[6:0];
            oe_nxt    = ~rd_data[7];
            state_nxt = RD;
          end
        end
        REG_HI: if (byte_done) begin
          cnt_nxt   = '0;
          hi_nxt    = sh[2:0];
          oe_nxt    = 1'b1;
          state_nxt = HI_ACK;
        end
        HI_ACK: if (scl_fall) begin
          oe_nxt    = 1'b0;
          state_nxt = REG_LO;
        end
        REG_LO: if (byte_done) begin
          cnt_nxt   = '0;
          addr_nxt  = {hi, sh};
          aack_nxt  = 1'b1;
          oe_nxt    = 1'b1;
          state_nxt = LO_ACK;
        end
        LO_ACK: if (scl_fall) begin
          oe_nxt    = 1'b0;
          aack_nxt  = 1'b0;
          state_nxt = WR;
        end
        WR: if (byte_done) begin
          cnt_nxt   = '0;
          data_nxt  = sh;
          dack_nxt  = 1'b1;
          oe_nxt    = 1'b1;
          state_nxt = WR_ACK;
        end
        WR_ACK: if (scl_fall) begin
          oe_nxt    = 1'b0;
          dack_nxt  = 1'b0;
          state_nxt = WR;
        end
        RD: begin
          if (bit_in) begin
            cnt_nxt = cnt + 4'd1;
          end else if (byte_done) begin
            cnt_nxt   = '0;
            oe_nxt    = 1'b0;
            state_nxt = RD_MACK;
          end else if (scl_fall) begin
            tx_nxt = {tx[5:0], 1'b0};
            oe_nxt = ~tx[6];
          end
        end
        // Pointer advances at the master-ACK sample so rd_data has half an SCL period to settle.
        RD_MACK: begin
          if (scl_rise) begin
            if (!sda) begin
              addr_nxt = i2c_addr + 11'd1;
              aack_nxt = 1'b1;
            end else begin
              state_nxt = IGNORE;
            end
          end else if (scl_fall && i2c_addr_ack) begin
            aack_nxt  = 1'b0;
            tx_nxt    = rd_data[6:0];
            oe_nxt    = ~rd_data[7];
            state_nxt = RD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_frontend.sv
// Directed bench for i2c_slave_frontend: bit-banged I2C master on an open-drain SDA model,
// table of write transactions plus hand-written read, early-STOP and reset sequences.
module tb_i2c_slave_frontend;

  logic        Clock = 1'b0;
  logic        reset = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [7:0]  rd_data;
  logic        i2c_RW;
  logic [10:0] i2c_addr;
  logic [7:0]  i2c_data;
  logic        i2c_addr_ack;
  logic        i2c_data_ack;
  logic        stop;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  assign sda_in  = m_sda & ~sda_oe;
  assign rd_data = i2c_addr[7:0] ^ 8'hC3;

  i2c_slave_frontend #(.DEV_ADDR(7'h42), .SYNC(2)) dut (
    .Clock        (Clock),
    .reset        (reset),
    .scl_in       (m_scl),
    .sda_in       (sda_in),
    .sda_oe       (sda_oe),
    .rd_data      (rd_data),
    .i2c_RW       (i2c_RW),
    .i2c_addr     (i2c_addr),
    .i2c_data     (i2c_data),
    .i2c_addr_ack (i2c_addr_ack),
    .i2c_data_ack (i2c_data_ack),
    .stop         (stop)
  );

  int          addr_rises, data_rises, oe_rises, stop_rises, stop_cycles;
  logic [10:0] addr_log[$];
  logic [7:0]  data_log[$];
  logic        aack_q = 1'b0, dack_q = 1'b0, oe_q = 1'b0, stop_q = 1'b0;

  always @(negedge Clock) begin
    if (i2c_addr_ack && !aack_q) begin
      addr_rises++;
      addr_log.push_back(i2c_addr);
    end
    if (i2c_data_ack && !dack_q) begin
      data_rises++;
      data_log.push_back(i2c_data);
    end
    if (sda_oe && !oe_q) oe_rises++;
    if (stop && !stop_q) stop_rises++;
    if (stop) stop_cycles++;
    aack_q = i2c_addr_ack;
    dack_q = i2c_data_ack;
    oe_q   = sda_oe;
    stop_q = stop;
  end

  task automatic clear_mon();
    addr_rises  = 0;
    data_rises  = 0;
    oe_rises    = 0;
    stop_rises  = 0;
    stop_cycles = 0;
    addr_log.delete();
    data_log.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic qw();
    repeat (8) @(posedge Clock);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; qw();
    m_scl = 1'b1; qw();
    m_sda = 1'b0; qw();
    m_scl = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; qw();
    m_scl = 1'b1; qw();
    m_sda = 1'b1; qw();
  endtask

  task automatic clk_bit(input logic b);
    m_sda = b; qw();
    m_scl = 1'b1; qw(); qw();
    m_scl = 1'b0; qw();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) clk_bit(b[i]);
    clk_bit(1'b1);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; qw();
      m_scl = 1'b1; qw();
      b[i] = sda_in;
      qw();
      m_scl = 1'b0; qw();
    end
    clk_bit(~mack);
    m_sda = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  dev, hi, lo, d0, d1;
    int          nd;
    int          e_oe, e_ar, e_dr;
    logic [10:0] e_addr;
    logic [7:0]  e_data, e_first;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] rb;
    int oe_snap;

    vecs[0] = '{dev:8'h84, hi:8'h05, lo:8'h3A, d0:8'hAA, d1:8'h55, nd:2,
                e_oe:5, e_ar:1, e_dr:2, e_addr:11'h53A, e_data:8'h55, e_first:8'hAA};
    vecs[1] = '{dev:8'h84, hi:8'hFD, lo:8'h12, d0:8'h00, d1:8'h00, nd:1,
                e_oe:4, e_ar:1, e_dr:1, e_addr:11'h512, e_data:8'h00, e_first:8'h00};
    vecs[2] = '{dev:8'h86, hi:8'h01, lo:8'h02, d0:8'h33, d1:8'h00, nd:1,
                e_oe:0, e_ar:0, e_dr:0, e_addr:11'h512, e_data:8'h00, e_first:8'h00};
    vecs[3] = '{dev:8'h84, hi:8'h07, lo:8'hFF, d0:8'h00, d1:8'h00, nd:0,
                e_oe:3, e_ar:1, e_dr:0, e_addr:11'h7FF, e_data:8'h00, e_first:8'h00};

    clear_mon();
    repeat (4) @(posedge Clock);
    #1;
    chk("rst_oe",   32'(sda_oe), 0);
    chk("rst_rw",   32'(i2c_RW), 0);
    chk("rst_addr", 32'(i2c_addr), 0);
    chk("rst_data", 32'(i2c_data), 0);
    chk("rst_aack", 32'(i2c_addr_ack), 0);
    chk("rst_dack", 32'(i2c_data_ack), 0);
    chk("rst_stop", 32'(stop), 0);
    reset = 1'b1;
    qw();

    for (int v = 0; v < 4; v++) begin
      clear_mon();
      i2c_start();
      send_byte(vecs[v].dev);
      send_byte(vecs[v].hi);
      send_byte(vecs[v].lo);
      if (vecs[v].nd > 0) send_byte(vecs[v].d0);
      if (vecs[v].nd > 1) send_byte(vecs[v].d1);
      i2c_stop();
      qw();
      chk($sformatf("v%0d_slave_acks", v), 32'(oe_rises), 32'(vecs[v].e_oe));
      chk($sformatf("v%0d_addr_rises", v), 32'(addr_rises), 32'(vecs[v].e_ar));
      chk($sformatf("v%0d_addr", v), 32'(i2c_addr), 32'(vecs[v].e_addr));
      chk($sformatf("v%0d_data_rises", v), 32'(data_rises), 32'(vecs[v].e_dr));
      chk($sformatf("v%0d_data", v), 32'(i2c_data), 32'(vecs[v].e_data));
      chk($sformatf("v%0d_rw", v), 32'(i2c_RW), 1);
      chk($sformatf("v%0d_stop_rises", v), 32'(stop_rises), 1);
      chk($sformatf("v%0d_stop_width", v), 32'(stop_cycles), 1);
      chk($sformatf("v%0d_oe_idle", v), 32'(sda_oe), 0);
      if (vecs[v].e_ar > 0 && addr_log.size() > 0)
        chk($sformatf("v%0d_addr_at_ack", v), 32'(addr_log[0]), 32'(vecs[v].e_addr));
      if (vecs[v].e_dr > 0 && data_log.size() > 0)
        chk($sformatf("v%0d_first_data", v), 32'(data_log[0]), 32'(vecs[v].e_first));
    end

    // Pointer set to 0x7FF, repeated START, read three bytes across the wrap.
    i2c_start();
    send_byte(8'h84);
    send_byte(8'h07);
    send_byte(8'hFF);
    clear_mon();
    i2c_start();
    send_byte(8'h85);
    chk("rd_rw", 32'(i2c_RW), 0);
    read_byte(1'b1, rb);
    chk("rd_byte0", 32'(rb), 32'h3C);
    read_byte(1'b1, rb);
    chk("rd_byte1", 32'(rb), 32'hC3);
    read_byte(1'b0, rb);
    chk("rd_byte2", 32'(rb), 32'hC2);
    chk("rd_nack_release", 32'(sda_oe), 0);
    oe_snap = oe_rises;
    clk_bit(1'b1);
    clk_bit(1'b1);
    chk("rd_ignore_quiet", 32'(oe_rises), 32'(oe_snap));
    i2c_stop();
    qw();
    chk("rd_addr_rises", 32'(addr_rises), 3);
    if (addr_log.size() == 3) begin
      chk("rd_ack_addr0", 32'(addr_log[0]), 32'h7FF);
      chk("rd_ack_addr1", 32'(addr_log[1]), 32'h000);
      chk("rd_ack_addr2", 32'(addr_log[2]), 32'h001);
    end
    chk("rd_final_addr", 32'(i2c_addr), 32'h001);
    chk("rd_stop_rises", 32'(stop_rises), 1);

    // STOP straight after the high pointer byte leaves the pointer alone.
    clear_mon();
    i2c_start();
    send_byte(8'h84);
    send_byte(8'h03);
    i2c_stop();
    qw();
    chk("early_stop_addr", 32'(i2c_addr), 32'h001);
    chk("early_stop_addr_rises", 32'(addr_rises), 0);
    chk("early_stop_pulse", 32'(stop_rises), 1);

    // Reset while the slave is acknowledging a write byte.
    i2c_start();
    send_byte(8'h84);
    send_byte(8'h02);
    send_byte(8'h10);
    for (int i = 7; i >= 0; i--) clk_bit(1'b1 ^ i[0]);
    m_sda = 1'b1; qw();
    m_scl = 1'b1; qw();
    chk("mid_oe_driven", 32'(sda_oe), 1);
    chk("mid_dack", 32'(i2c_data_ack), 1);
    @(negedge Clock);
    reset = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("mid_rst_oe", 32'(sda_oe), 0);
    chk("mid_rst_dack", 32'(i2c_data_ack), 0);
    chk("mid_rst_addr", 32'(i2c_addr), 0);
    chk("mid_rst_data", 32'(i2c_data), 0);
    chk("mid_rst_rw", 32'(i2c_RW), 0);
    reset = 1'b1;
    qw();
    m_scl = 1'b0; qw();
    i2c_stop();
    qw();

    clear_mon();
    i2c_start();
    send_byte(8'h84);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h77);
    i2c_stop();
    qw();
    chk("fresh_acks", 32'(oe_rises), 4);
    chk("fresh_addr_rises", 32'(addr_rises), 1);
    chk("fresh_addr", 32'(i2c_addr), 32'h123);
    chk("fresh_data", 32'(i2c_data), 32'h77);
    chk("fresh_stop", 32'(stop_rises), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
